// File: rtl/collatz_pkg.sv
// Shared types and constants for the Collatz range-sum kernel.
package collatz_pkg;

  localparam int unsigned J_W   = 16;
  localparam int unsigned IDX_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STEP,
    ACCUM,
    DONE
  } state_t;

endpackage

// File: rtl/collatz_step.sv
// One Collatz iteration: halve even values, map odd values to 3m+1 (mod 2^WIDTH).
module collatz_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] next_m,
  output logic             is_one
);

  always_comb begin
    if (m[0]) begin
      next_m = WIDTH'((m << 1) + m + WIDTH'(1));
    end else begin
      next_m = m >> 1;
    end
    is_one = (next_m == WIDTH'(1));
  end

endmodule

// File: rtl/collatz_range_sum.sv
// Sums Collatz stopping times over COUNT consecutive integers from n, one step per cycle.
// Optional per-element step-limit watchdog: define COLLATZ_STEP_LIMIT_EN.
module collatz_range_sum
  import collatz_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned COUNT     = 30,
  parameter int unsigned SUM_WIDTH = 32,
  parameter int unsigned MAX_STEPS = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     n,
  output logic                 ready,
  output logic                 finish,
  output logic [SUM_WIDTH-1:0] return_val,
  output logic                 timeout
);

`ifdef COLLATZ_STEP_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(COUNT - 1);
  localparam logic [J_W-1:0]   STEP_LIMIT = J_W'(MAX_STEPS);

  state_t               state, state_next;
  logic [WIDTH-1:0]     n_reg, n_reg_next;
  logic [IDX_W-1:0]     idx, idx_next;
  logic [WIDTH-1:0]     m, m_next;
  logic [J_W-1:0]       j, j_next;
  logic [SUM_WIDTH-1:0] sum, sum_next;
  logic                 finish_next;
  logic [SUM_WIDTH-1:0] return_val_next;
  logic                 timeout_next;

  logic [WIDTH-1:0]     first_m;
  logic [WIDTH-1:0]     step_m;
  logic                 step_is_one;
  logic [J_W-1:0]       j_inc;
  logic [SUM_WIDTH-1:0] sum_inc;

  collatz_step #(.WIDTH(WIDTH)) u_step (
    .m      (m),
    .next_m (step_m),
    .is_one (step_is_one)
  );

  assign first_m = WIDTH'(n_reg + WIDTH'(idx));
  assign j_inc   = J_W'(j + J_W'(1));
  assign sum_inc = SUM_WIDTH'(sum + SUM_WIDTH'(j));
  assign ready   = (state == IDLE);

  // Next-state and register-update logic
  always_comb begin
    state_next      = state;
    n_reg_next      = n_reg;
    idx_next        = idx;
    m_next          = m;
    j_next          = j;
    sum_next        = sum;
    finish_next     = 1'b0;
    return_val_next = return_val;
    timeout_next    = timeout;

    case (state)
      IDLE: begin
        if (start) begin
          n_reg_next      = n;
          idx_next        = '0;
          sum_next        = '0;
          return_val_next = '0;
          timeout_next    = 1'b0;
          state_next      = LOAD;
        end
      end
      LOAD: begin
        m_next     = first_m;
        j_next     = '0;
        state_next = (first_m == WIDTH'(1)) ? ACCUM : STEP;
      end
      STEP: begin
        m_next = step_m;
        j_next = j_inc;
        if (step_is_one) begin
          state_next = ACCUM;
        end else if (LIMIT_EN && (j_inc == STEP_LIMIT)) begin
          state_next   = ACCUM;
          timeout_next = 1'b1;
        end
      end
      ACCUM: begin
        sum_next = sum_inc;
        idx_next = IDX_W'(idx + IDX_W'(1));
        // Result is registered on entry to DONE so it is valid alongside finish.
        if (idx == LAST_IDX) begin
          return_val_next = sum_inc;
          finish_next     = 1'b1;
          state_next      = DONE;
        end else begin
          state_next = LOAD;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      n_reg      <= '0;
      idx        <= '0;
      m          <= '0;
      j          <= '0;
      sum        <= '0;
      finish     <= 1'b0;
      return_val <= '0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_next;
      n_reg      <= n_reg_next;
      idx        <= idx_next;
      m          <= m_next;
      j          <= j_next;
      sum        <= sum_next;
      finish     <= finish_next;
      return_val <= return_val_next;
      timeout    <= timeout_next;
    end
  end

endmodule

// File: tb/tb_collatz_range_sum.sv
// Directed bench for collatz_range_sum: default (COUNT=30), COUNT=1 and COUNT=2 instances.
module tb_collatz_range_sum;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_v  [3];
  logic [31:0] n_v      [3];
  logic        ready_v  [3];
  logic        finish_v [3];
  logic        timeout_v[3];
  logic [31:0] ret_v    [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  collatz_range_sum #(.WIDTH(32), .COUNT(30), .SUM_WIDTH(32), .MAX_STEPS(1024)) dut_a (
    .clk(clk), .reset(reset), .start(start_v[0]), .n(n_v[0]), .ready(ready_v[0]),
    .finish(finish_v[0]), .return_val(ret_v[0]), .timeout(timeout_v[0])
  );

  collatz_range_sum #(.WIDTH(32), .COUNT(1), .SUM_WIDTH(32), .MAX_STEPS(100)) dut_b (
    .clk(clk), .reset(reset), .start(start_v[1]), .n(n_v[1]), .ready(ready_v[1]),
    .finish(finish_v[1]), .return_val(ret_v[1]), .timeout(timeout_v[1])
  );

  collatz_range_sum #(.WIDTH(32), .COUNT(2), .SUM_WIDTH(32), .MAX_STEPS(16)) dut_c (
    .clk(clk), .reset(reset), .start(start_v[2]), .n(n_v[2]), .ready(ready_v[2]),
    .finish(finish_v[2]), .return_val(ret_v[2]), .timeout(timeout_v[2])
  );

  typedef struct {
    int          d;
    logic [31:0] n;
    logic [31:0] sum;
    int          lat;
    logic        to;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_ready(input int d, input string name);
    int k = 0;
    while (!ready_v[d] && k < 1000) begin
      @(posedge clk); #1;
      k++;
    end
    check({name, " ready_wait"}, 64'(ready_v[d]), 64'd1);
  endtask

  // Start a job, then count cycles from the acceptance edge until finish.
  task automatic run_job(input int d, input logic [31:0] nv, input logic [31:0] exp_sum,
                         input int exp_lat, input logic exp_to, input string name);
    int cyc;
    wait_ready(d, name);
    start_v[d] = 1'b1;
    n_v[d]     = nv;
    @(posedge clk); #1;
    start_v[d] = 1'b0;
    n_v[d]     = 32'hDEAD_BEEF;
    cyc = 1;
    check({name, " busy"}, 64'(ready_v[d]), 64'd0);
    check({name, " cleared"}, 64'(ret_v[d]), 64'd0);
    while (!finish_v[d] && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({name, " finish"}, 64'(finish_v[d]), 64'd1);
    check({name, " latency"}, 64'(cyc), 64'(exp_lat));
    check({name, " sum"}, 64'(ret_v[d]), 64'(exp_sum));
    check({name, " timeout"}, 64'(timeout_v[d]), 64'(exp_to));
    @(posedge clk); #1;
    check({name, " ready_after"}, 64'(ready_v[d]), 64'd1);
    check({name, " finish_pulse"}, 64'(finish_v[d]), 64'd0);
    check({name, " held"}, 64'(ret_v[d]), 64'(exp_sum));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int cyc;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      n_v[i]     = '0;
    end

    tbl.push_back('{1, 32'd1, 32'd0, 3, 1'b0});
    tbl.push_back('{1, 32'd2, 32'd1, 4, 1'b0});
`ifdef COLLATZ_STEP_LIMIT_EN
    tbl.push_back('{1, 32'd27, 32'd100, 103, 1'b1});
`else
    tbl.push_back('{1, 32'd27, 32'd111, 114, 1'b0});
`endif
    tbl.push_back('{1, 32'd2, 32'd1, 4, 1'b0});
    tbl.push_back('{1, 32'd6, 32'd8, 11, 1'b0});
    tbl.push_back('{1, 32'd7, 32'd16, 19, 1'b0});
    tbl.push_back('{1, 32'd9, 32'd19, 22, 1'b0});
    tbl.push_back('{2, 32'd3, 32'd9, 14, 1'b0});
    tbl.push_back('{2, 32'd1, 32'd1, 6, 1'b0});
`ifdef COLLATZ_STEP_LIMIT_EN
    tbl.push_back('{2, 32'd0, 32'd16, 21, 1'b1});
    tbl.push_back('{2, 32'd1, 32'd1, 6, 1'b0});
`endif

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_ready%0d", i), 64'(ready_v[i]), 64'd1);
      check($sformatf("reset_finish%0d", i), 64'(finish_v[i]), 64'd0);
      check($sformatf("reset_ret%0d", i), 64'(ret_v[i]), 64'd0);
      check($sformatf("reset_timeout%0d", i), 64'(timeout_v[i]), 64'd0);
    end

    // Back-to-back table jobs: each start lands in the first ready cycle after finish
    foreach (tbl[i]) begin
      run_job(tbl[i].d, tbl[i].n, tbl[i].sum, tbl[i].lat, tbl[i].to, $sformatf("vec%0d", i));
    end

    // Default job n=1 with a stray start/n pulse mid-job that must be ignored
    wait_ready(0, "dflt");
    start_v[0] = 1'b1;
    n_v[0]     = 32'd1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    cyc = 1;
    while (!finish_v[0] && cyc < 700) begin
      if (cyc == 20) begin
        start_v[0] = 1'b1;
        n_v[0]     = 32'd5;
      end else begin
        start_v[0] = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start_v[0] = 1'b0;
    check("dflt finish", 64'(finish_v[0]), 64'd1);
    check("dflt latency", 64'(cyc), 64'd502);
    check("dflt sum", 64'(ret_v[0]), 64'd441);
    check("dflt timeout", 64'(timeout_v[0]), 64'd0);
    @(posedge clk); #1;
    check("dflt finish_pulse", 64'(finish_v[0]), 64'd0);
    check("dflt held", 64'(ret_v[0]), 64'd441);

    // Reset in cycle 50 of a default job discards everything
    wait_ready(0, "rst");
    start_v[0] = 1'b1;
    n_v[0]     = 32'd1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    cyc = 1;
    while (cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("rst busy", 64'(ready_v[0]), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst ready", 64'(ready_v[0]), 64'd1);
    check("rst finish", 64'(finish_v[0]), 64'd0);
    check("rst ret", 64'(ret_v[0]), 64'd0);
    check("rst timeout", 64'(timeout_v[0]), 64'd0);

    run_job(0, 32'd1, 32'd441, 502, 1'b0, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
